// File: rtl/can_err_pkg.sv
// Shared definitions for the CAN error-frame sequencer and fault-confinement logic:
// FSM encoding, fault-state codes, default bit lengths and the fault-state derivation.
package can_err_pkg;

  localparam int FLAG_BITS_DEF   = 6;
  localparam int DELIM_BITS_DEF  = 8;
  localparam int IFS_BITS_DEF    = 3;
  localparam int PASSIVE_LIM_DEF = 128;
  localparam int BUSOFF_LIM_DEF  = 256;
  localparam int RECOV_SEQS_DEF  = 128;
  localparam int RECOV_RUN       = 11;

  localparam logic [8:0] TEC_MAX     = 9'd511;
  localparam logic [7:0] REC_MAX     = 8'd255;
  localparam logic [7:0] REC_OK_CAP  = 8'd128;
  localparam logic [7:0] REC_OK_LOAD = 8'd120;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_WAIT_REC,
    S_DELIM,
    S_IFS,
    S_BUSOFF
  } err_state_e;

  typedef enum logic [1:0] {
    FS_ACTIVE  = 2'b00,
    FS_PASSIVE = 2'b01,
    FS_BUSOFF  = 2'b10
  } fault_state_e;

  function automatic fault_state_e fault_of(input logic [8:0] tec, input logic [7:0] rec,
                                            input int passive_lim, input int busoff_lim);
    if (int'(tec) >= busoff_lim) return FS_BUSOFF;
    if (int'(tec) >= passive_lim || int'(rec) >= passive_lim) return FS_PASSIVE;
    return FS_ACTIVE;
  endfunction

endpackage

// File: rtl/can_fault_confine.sv
// TEC/REC bookkeeping with saturation, plus fault-state derivation from the updated counts.
// fault_nxt is the combinational look-ahead the sequencer uses to act in the same edge.
module can_fault_confine
  import can_err_pkg::*;
#(
  parameter int PASSIVE_LIM = PASSIVE_LIM_DEF,
  parameter int BUSOFF_LIM  = BUSOFF_LIM_DEF
) (
  input  logic         SP,
  input  logic         reset,
  input  logic         err_inc,
  input  logic         is_tx,
  input  logic         tx_ok,
  input  logic         rx_ok,
  input  logic         recover_clr,
  output logic [8:0]   TEC,
  output logic [7:0]   REC,
  output logic [1:0]   fault_state,
  output fault_state_e fault_nxt
);

  logic [8:0]   tec_q, tec_nxt;
  logic [7:0]   rec_q, rec_nxt;
  fault_state_e fs_q;

  // NOTE: every variable gets a default before the branches, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    tec_nxt = tec_q;
    rec_nxt = rec_q;
    if (recover_clr) begin
      tec_nxt = '0;
      rec_nxt = '0;
    end else if (err_inc) begin
      // An error in the same cycle as a success indication wins; the success is dropped.
      if (is_tx) tec_nxt = (tec_q > TEC_MAX - 9'd8) ? TEC_MAX : tec_q + 9'd8;
      else       rec_nxt = (rec_q == REC_MAX) ? REC_MAX : rec_q + 8'd1;
    end else begin
      if (tx_ok && tec_q != '0) tec_nxt = tec_q - 9'd1;
      if (rx_ok) begin
        if (rec_q >= REC_OK_CAP)  rec_nxt = REC_OK_LOAD;
        else if (rec_q != '0)     rec_nxt = rec_q - 8'd1;
      end
    end
    fault_nxt = fault_of(tec_nxt, rec_nxt, PASSIVE_LIM, BUSOFF_LIM);
  end

  // NOTE: sequential state is written only with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      tec_q <= '0;
      rec_q <= '0;
      fs_q  <= FS_ACTIVE;
    end else begin
      tec_q <= tec_nxt;
      rec_q <= rec_nxt;
      fs_q  <= fault_nxt;
    end
  end

  assign TEC         = tec_q;
  assign REC         = rec_q;
  assign fault_state = fs_q;

endmodule

// File: rtl/can_error_frame_ctrl.sv
// CAN error-frame sequencer: flag, delimiter, intermission and bus-off recovery,
// clocked once per bit at the sample point. All outputs are registered.
module can_error_frame_ctrl
  import can_err_pkg::*;
#(
  parameter int FLAG_BITS   = FLAG_BITS_DEF,
  parameter int DELIM_BITS  = DELIM_BITS_DEF,
  parameter int IFS_BITS    = IFS_BITS_DEF,
  parameter int PASSIVE_LIM = PASSIVE_LIM_DEF,
  parameter int BUSOFF_LIM  = BUSOFF_LIM_DEF,
  parameter int RECOV_SEQS  = RECOV_SEQS_DEF
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       ERROR,
  input  logic       is_tx,
  input  logic       tx_ok,
  input  logic       rx_ok,
  output logic       TX_ERR,
  output logic       err_busy,
  output logic       decoder_restart,
  output logic [8:0] TEC,
  output logic [7:0] REC,
  output logic [1:0] fault_state
);

  localparam int SEQ_W = $clog2(RECOV_SEQS + 1);

  err_state_e       state_q, state_nxt;
  logic [7:0]       cnt_q, cnt_nxt;
  logic [3:0]       run_q, run_nxt;
  logic [SEQ_W-1:0] seq_q, seq_nxt;
  logic             restart_nxt;
  logic             err_inc, recover_clr, ok_en;
  fault_state_e     fault_nxt;

  // A dominant bit inside the delimiter is a form error and counts like a fresh ERROR.
  assign err_inc     = (state_q == S_IDLE && ERROR) || (state_q == S_DELIM && !RX);
  assign recover_clr = (state_q == S_BUSOFF) && RX && (int'(run_q) == RECOV_RUN - 1) &&
                       (int'(seq_q) == RECOV_SEQS - 1);
  assign ok_en       = (state_q != S_BUSOFF);

  can_fault_confine #(
    .PASSIVE_LIM (PASSIVE_LIM),
    .BUSOFF_LIM  (BUSOFF_LIM)
  ) u_confine (
    .SP          (SP),
    .reset       (reset),
    .err_inc     (err_inc),
    .is_tx       (is_tx),
    .tx_ok       (tx_ok && ok_en),
    .rx_ok       (rx_ok && ok_en),
    .recover_clr (recover_clr),
    .TEC         (TEC),
    .REC         (REC),
    .fault_state (fault_state),
    .fault_nxt   (fault_nxt)
  );

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    run_nxt     = run_q;
    seq_nxt     = seq_q;
    restart_nxt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ERROR) begin
          state_nxt = S_FLAG;
          cnt_nxt   = '0;
        end
      end
      S_FLAG: begin
        if (int'(cnt_q) == FLAG_BITS - 1) state_nxt = S_WAIT_REC;
        else                              cnt_nxt   = cnt_q + 8'd1;
      end
      S_WAIT_REC: begin
        // The first recessive bit after superposed flags is already delimiter bit 1.
        if (RX) begin
          state_nxt = S_DELIM;
          cnt_nxt   = 8'd1;
        end
      end
      S_DELIM: begin
        if (!RX) begin
          state_nxt = S_FLAG;
          cnt_nxt   = '0;
        end else if (int'(cnt_q) == DELIM_BITS - 1) begin
          state_nxt = S_IFS;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      S_IFS: begin
        if (int'(cnt_q) == IFS_BITS - 1) begin
          state_nxt   = S_IDLE;
          cnt_nxt     = '0;
          restart_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      S_BUSOFF: begin
        if (!RX) begin
          run_nxt = '0;
        end else if (int'(run_q) == RECOV_RUN - 1) begin
          run_nxt = '0;
          if (recover_clr) begin
            seq_nxt     = '0;
            state_nxt   = S_IDLE;
            restart_nxt = 1'b1;
          end else begin
            seq_nxt = seq_q + SEQ_W'(1);
          end
        end else begin
          run_nxt = run_q + 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Bus-off pre-empts whatever part of the error frame was in progress.
    if (state_q != S_BUSOFF && fault_nxt == FS_BUSOFF) begin
      state_nxt = S_BUSOFF;
      cnt_nxt   = '0;
      run_nxt   = '0;
      seq_nxt   = '0;
    end
  end

  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      run_q           <= '0;
      seq_q           <= '0;
      TX_ERR          <= 1'b0;
      err_busy        <= 1'b0;
      decoder_restart <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      cnt_q           <= cnt_nxt;
      run_q           <= run_nxt;
      seq_q           <= seq_nxt;
      // An error-passive node sends a recessive (passive) flag.
      TX_ERR          <= (state_nxt == S_FLAG) && (fault_nxt == FS_ACTIVE);
      err_busy        <= (state_nxt != S_IDLE);
      decoder_restart <= restart_nxt;
    end
  end

endmodule
